axi_burst_mnq: RTL and testbench

- Parametrised AXI4 slave memory model. It is the successor of the single-beat simulation memory bridge.
- Accepts FIXED and INCR bursts of 1–256 beats, with a configurable data, address and ID width.
- Passes byte write strobes through to memory and reports SLVERR for unsupported requests.
- Sits between the SoC crossbar and the simulation RAM (DPI) port. Read and write channels run independently and concurrently.

---
 rtl/axi_mnq_pkg.sv | 25 ++
 rtl/axi_mnq_addr_gen.sv | 21 ++
 rtl/axi_burst_mnq.sv | 214 +++++++++++++++++++++
 tb/tb_axi_burst_mnq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mnq_pkg.sv
// rtl/axi_mnq_pkg.sv - shared encodings, FSM states and request checks for axi_burst_mnq
package axi_mnq_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  // A beat may not be wider than the data bus (max_log2 = log2 of the strobe width).
  function automatic logic size_ok(input logic [2:0] size, input int unsigned max_log2);
    return {29'b0, size} <= max_log2;
  endfunction

  // Only FIXED and INCR bursts with a bus-fitting size are served; all else is SLVERR.
  function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size,
                                   input int unsigned max_log2);
    return !(burst == BURST_FIXED || burst == BURST_INCR) || !size_ok(size, max_log2);
  endfunction

endpackage

// File: rtl/axi_mnq_addr_gen.sv
// rtl/axi_mnq_addr_gen.sv - next-beat and bus-aligned address for one burst
module axi_mnq_addr_gen
  import axi_mnq_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] aligned_addr
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  // INCR steps by the beat size and wraps modulo 2^ADDR_W; FIXED stays put.
  assign next_addr    = (burst == BURST_INCR) ? cur_addr + (ADDR_W'(1) << size) : cur_addr;
  assign aligned_addr = {cur_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

endmodule

// File: rtl/axi_burst_mnq.sv
// rtl/axi_burst_mnq.sv - AXI4 burst slave bridging to a simple memory port
module axi_burst_mnq
  import axi_mnq_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_aw_id,
  input  logic [ADDR_W-1:0] s_axi_aw_addr,
  input  logic [7:0]        s_axi_aw_len,
  input  logic [2:0]        s_axi_aw_size,
  input  logic [1:0]        s_axi_aw_burst,
  input  logic              s_axi_aw_valid,
  output logic              s_axi_aw_ready,
  input  logic [DATA_W-1:0] s_axi_w_data,
  input  logic [STRB_W-1:0] s_axi_w_strb,
  input  logic              s_axi_w_last,
  input  logic              s_axi_w_valid,
  output logic              s_axi_w_ready,
  output logic [ID_W-1:0]   s_axi_b_id,
  output logic [1:0]        s_axi_b_resp,
  output logic              s_axi_b_valid,
  input  logic              s_axi_b_ready,
  input  logic [ID_W-1:0]   s_axi_ar_id,
  input  logic [ADDR_W-1:0] s_axi_ar_addr,
  input  logic [7:0]        s_axi_ar_len,
  input  logic [2:0]        s_axi_ar_size,
  input  logic [1:0]        s_axi_ar_burst,
  input  logic              s_axi_ar_valid,
  output logic              s_axi_ar_ready,
  output logic [ID_W-1:0]   s_axi_r_id,
  output logic [DATA_W-1:0] s_axi_r_data,
  output logic [1:0]        s_axi_r_resp,
  output logic              s_axi_r_last,
  output logic              s_axi_r_valid,
  input  logic              s_axi_r_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [STRB_W-1:0] mem_wr_strb
);

  localparam int unsigned MAX_SIZE = $clog2(STRB_W);

  w_state_t          w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [7:0]        beat_cnt;
  logic              w_err;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_aligned;
  logic              w_hs;
  logic              w_final;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [8:0]        r_remaining;
  logic              r_err;
  logic [ADDR_W-1:0] r_next;
  logic [ADDR_W-1:0] r_aligned;
  logic              r_issue;

  axi_mnq_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr (
    .cur_addr(w_addr), .size(w_size), .burst(w_burst),
    .next_addr(w_next), .aligned_addr(w_aligned)
  );

  axi_mnq_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr (
    .cur_addr(r_addr), .size(r_size), .burst(r_burst),
    .next_addr(r_next), .aligned_addr(r_aligned)
  );

  assign w_hs    = s_axi_w_valid && s_axi_w_ready;
  assign w_final = (beat_cnt == w_len);

  // Write command is issued in the same cycle as the W handshake; empty strobes skip memory.
  assign mem_wr_en   = w_hs && !w_err && (s_axi_w_strb != '0);
  assign mem_wr_addr = w_aligned;
  assign mem_wr_data = mem_wr_en ? s_axi_w_data : '0;
  assign mem_wr_strb = mem_wr_en ? s_axi_w_strb : '0;

  // A read beat issues when beats remain and the R output register is free or draining.
  assign r_issue     = (r_state == R_BURST) && (r_remaining != 9'd0) &&
                       (!s_axi_r_valid || s_axi_r_ready);
  assign mem_rd_en   = r_issue && !r_err;
  assign mem_rd_addr = r_aligned;

  // Write FSM: accept AW, count W beats to len, then hold B until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state        <= W_IDLE;
      w_id           <= '0;
      w_addr         <= '0;
      w_len          <= '0;
      w_size         <= '0;
      w_burst        <= '0;
      beat_cnt       <= '0;
      w_err          <= 1'b0;
      s_axi_aw_ready <= 1'b0;
      s_axi_w_ready  <= 1'b0;
      s_axi_b_valid  <= 1'b0;
      s_axi_b_id     <= '0;
      s_axi_b_resp   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_aw_valid && s_axi_aw_ready) begin
            w_id           <= s_axi_aw_id;
            w_addr         <= s_axi_aw_addr;
            w_len          <= s_axi_aw_len;
            w_size         <= s_axi_aw_size;
            w_burst        <= s_axi_aw_burst;
            beat_cnt       <= '0;
            w_err          <= req_err(s_axi_aw_burst, s_axi_aw_size, MAX_SIZE);
            s_axi_aw_ready <= 1'b0;
            s_axi_w_ready  <= 1'b1;
            w_state        <= W_DATA;
          end else begin
            s_axi_aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr   <= w_next;
            beat_cnt <= beat_cnt + 8'd1;
            if (s_axi_w_last != w_final) w_err <= 1'b1;
            // len is authoritative for burst end; a stray w_last only flags the error.
            if (w_final) begin
              s_axi_w_ready <= 1'b0;
              s_axi_b_valid <= 1'b1;
              s_axi_b_id    <= w_id;
              s_axi_b_resp  <= (w_err || !s_axi_w_last) ? RESP_SLVERR : RESP_OKAY;
              w_state       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_b_valid && s_axi_b_ready) begin
            s_axi_b_valid  <= 1'b0;
            s_axi_aw_ready <= 1'b1;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, stream len+1 beats through a single output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= R_IDLE;
      r_addr         <= '0;
      r_size         <= '0;
      r_burst        <= '0;
      r_remaining    <= '0;
      r_err          <= 1'b0;
      s_axi_ar_ready <= 1'b0;
      s_axi_r_id     <= '0;
      s_axi_r_data   <= '0;
      s_axi_r_resp   <= '0;
      s_axi_r_last   <= 1'b0;
      s_axi_r_valid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_ar_valid && s_axi_ar_ready) begin
            s_axi_r_id     <= s_axi_ar_id;
            r_addr         <= s_axi_ar_addr;
            r_size         <= s_axi_ar_size;
            r_burst        <= s_axi_ar_burst;
            r_err          <= req_err(s_axi_ar_burst, s_axi_ar_size, MAX_SIZE);
            r_remaining    <= {1'b0, s_axi_ar_len} + 9'd1;
            s_axi_ar_ready <= 1'b0;
            r_state        <= R_BURST;
          end else begin
            s_axi_ar_ready <= 1'b1;
          end
        end
        R_BURST: begin
          if (r_issue) begin
            s_axi_r_data  <= r_err ? '0 : mem_rd_data;
            s_axi_r_resp  <= r_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_r_last  <= (r_remaining == 9'd1);
            s_axi_r_valid <= 1'b1;
            r_remaining   <= r_remaining - 9'd1;
            r_addr        <= r_next;
          end else if (s_axi_r_valid && s_axi_r_ready) begin
            s_axi_r_valid <= 1'b0;
            if (s_axi_r_last) begin
              s_axi_r_last   <= 1'b0;
              s_axi_ar_ready <= 1'b1;
              r_state        <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mnq.sv
// tb/tb_axi_burst_mnq.sv - self-checking bench for axi_burst_mnq
module tb_axi_burst_mnq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  aw_id = '0, ar_id = '0, b_id, r_id;
  logic [63:0] aw_addr = '0, ar_addr = '0;
  logic [7:0]  aw_len = '0, ar_len = '0;
  logic [2:0]  aw_size = '0, ar_size = '0;
  logic [1:0]  aw_burst = '0, ar_burst = '0, b_resp, r_resp;
  logic        aw_valid = 1'b0, aw_ready, ar_valid = 1'b0, ar_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0, w_valid = 1'b0, w_ready;
  logic        b_valid, b_ready = 1'b0;
  logic [63:0] r_data;
  logic        r_last, r_valid, r_ready = 1'b0;
  logic        mem_rd_en, mem_wr_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [7:0]  mem_wr_strb;

  always #5 clk = ~clk;

  axi_burst_mnq dut (
    .clk(clk), .rst(rst),
    .s_axi_aw_id(aw_id), .s_axi_aw_addr(aw_addr), .s_axi_aw_len(aw_len),
    .s_axi_aw_size(aw_size), .s_axi_aw_burst(aw_burst), .s_axi_aw_valid(aw_valid),
    .s_axi_aw_ready(aw_ready),
    .s_axi_w_data(w_data), .s_axi_w_strb(w_strb), .s_axi_w_last(w_last),
    .s_axi_w_valid(w_valid), .s_axi_w_ready(w_ready),
    .s_axi_b_id(b_id), .s_axi_b_resp(b_resp), .s_axi_b_valid(b_valid), .s_axi_b_ready(b_ready),
    .s_axi_ar_id(ar_id), .s_axi_ar_addr(ar_addr), .s_axi_ar_len(ar_len),
    .s_axi_ar_size(ar_size), .s_axi_ar_burst(ar_burst), .s_axi_ar_valid(ar_valid),
    .s_axi_ar_ready(ar_ready),
    .s_axi_r_id(r_id), .s_axi_r_data(r_data), .s_axi_r_resp(r_resp), .s_axi_r_last(r_last),
    .s_axi_r_valid(r_valid), .s_axi_r_ready(r_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb)
  );

  // Simulation RAM: combinational read, byte-strobed write on the clock edge.
  logic [63:0] mem [0:255];
  assign mem_rd_data = mem[mem_rd_addr[10:3]];
  always @(posedge clk) begin
    if (mem_wr_en)
      for (int b = 0; b < 8; b++)
        if (mem_wr_strb[b]) mem[mem_wr_addr[10:3]][8*b +: 8] <= mem_wr_data[8*b +: 8];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of memory plus expected transaction queues.
  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wr_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  logic [7:0]  shadow [logic [63:0]];
  wr_t         exp_wr_q[$];
  logic [63:0] exp_rd_q[$];
  r_t          exp_r_q[$];
  b_t          exp_b_q[$];
  logic [63:0] obs_wr_addr[$];
  logic [63:0] last_r_data;
  logic [1:0]  last_r_resp, last_b_resp;
  int          r_hs_cnt = 0;
  logic        model_off = 1'b0;

  function automatic logic model_err(input logic [1:0] burst, input logic [2:0] size);
    return (burst > 2'd1) || (size > 3'd3);
  endfunction

  function automatic logic [63:0] word_of(input logic [63:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) begin
      logic [63:0] ba;
      ba = {a[63:3], 3'b000} + 64'(b);
      w[8*b +: 8] = shadow.exists(ba) ? shadow[ba] : 8'h00;
    end
    return w;
  endfunction

  // Compare process: every cycle, check whatever the DUT presents against the model.
  logic        stall_prev = 1'b0;
  logic [63:0] held_data;
  logic        held_last;
  logic [1:0]  held_resp;
  always @(negedge clk) begin
    if (rst || model_off) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_wr_en) begin
        check("wr_expected", 64'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("mem_wr_addr", mem_wr_addr, e.addr);
          check("mem_wr_data", mem_wr_data, e.data);
          check("mem_wr_strb", 64'(mem_wr_strb), 64'(e.strb));
        end
        obs_wr_addr.push_back(mem_wr_addr);
      end
      if (mem_rd_en) begin
        check("rd_expected", 64'(exp_rd_q.size() != 0), 1);
        if (exp_rd_q.size() != 0) check("mem_rd_addr", mem_rd_addr, exp_rd_q.pop_front());
      end
      if (stall_prev) begin
        check("hold_valid", 64'(r_valid), 1);
        check("hold_data", r_data, held_data);
        check("hold_last", 64'(r_last), 64'(held_last));
        check("hold_resp", 64'(r_resp), 64'(held_resp));
      end
      stall_prev = r_valid && !r_ready;
      held_data  = r_data;
      held_last  = r_last;
      held_resp  = r_resp;
      if (r_valid && r_ready) begin
        r_hs_cnt++;
        last_r_data = r_data;
        last_r_resp = r_resp;
        check("r_expected", 64'(exp_r_q.size() != 0), 1);
        if (exp_r_q.size() != 0) begin
          r_t e;
          e = exp_r_q.pop_front();
          check("r_data", r_data, e.data);
          check("r_resp", 64'(r_resp), 64'(e.resp));
          check("r_last", 64'(r_last), 64'(e.last));
          check("r_id", 64'(r_id), 64'(e.id));
        end
      end
      if (b_valid && b_ready) begin
        last_b_resp = b_resp;
        check("b_expected", 64'(exp_b_q.size() != 0), 1);
        if (exp_b_q.size() != 0) begin
          b_t e;
          e = exp_b_q.pop_front();
          check("b_id", 64'(b_id), 64'(e.id));
          check("b_resp", 64'(b_resp), 64'(e.resp));
        end
      end
    end
  end

  function automatic logic sig_sel(input int which);
    case (which)
      0: return aw_ready;
      1: return w_ready;
      2: return ar_ready;
      default: return b_valid;
    endcase
  endfunction

  // Wait for a handshake signal, then return just after the edge that completes it.
  task automatic wait_sig(input int which, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sig_sel(which)) break;
      n++;
      if (n > 100) begin
        check({name, "_timeout"}, 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [63:0] dbase, input logic [7:0] strb);
    logic        err;
    logic [63:0] a;
    err = model_err(burst, size);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (!err && strb != 8'h00) begin
        wr_t e;
        e.addr = {a[63:3], 3'b000};
        e.data = dbase + 64'(i);
        e.strb = strb;
        exp_wr_q.push_back(e);
        for (int b = 0; b < 8; b++)
          if (strb[b]) shadow[e.addr + 64'(b)] = e.data[8*b +: 8];
      end
      if (burst == 2'b01) a = a + (64'd1 << size);
    end
    begin
      b_t eb;
      eb.id = id;
      eb.resp = err ? 2'b10 : 2'b00;
      exp_b_q.push_back(eb);
    end
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    wait_sig(0, "aw");
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = dbase + 64'(i); w_strb = strb; w_last = (i == int'(len)); w_valid = 1'b1;
      wait_sig(1, "w");
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    wait_sig(3, "b");
    b_ready = 1'b0;
  endtask

  // pat bit k is r_ready for the k-th cycle after the AR handshake.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [15:0] pat,
                         output int first_k, output int last_k, output int beats);
    logic        err;
    logic [63:0] a;
    int          start;
    err = model_err(burst, size);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      r_t e;
      e.id = id;
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.data = err ? 64'h0 : word_of(a);
      exp_r_q.push_back(e);
      if (!err) exp_rd_q.push_back({a[63:3], 3'b000});
      if (burst == 2'b01) a = a + (64'd1 << size);
    end
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
    wait_sig(2, "ar");
    ar_valid = 1'b0;
    start = r_hs_cnt;
    first_k = -1;
    last_k = -1;
    for (int k = 0; k < 600; k++) begin
      r_ready = (k < 16) ? pat[k] : 1'b1;
      @(negedge clk); #1;
      if (r_valid && first_k < 0) first_k = k;
      if (r_hs_cnt - start == int'(len) + 1) begin
        last_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    r_ready = 1'b0;
    beats = r_hs_cnt - start;
    check("r_burst_done", 64'(last_k >= 0), 1);
  endtask

  int fk, lk, nb;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    #12;
    check("rst_aw_ready", 64'(aw_ready), 0);
    check("rst_w_ready", 64'(w_ready), 0);
    check("rst_ar_ready", 64'(ar_ready), 0);
    check("rst_b_valid", 64'(b_valid), 0);
    check("rst_r_valid", 64'(r_valid), 0);
    check("rst_mem_en", {62'b0, mem_wr_en, mem_rd_en}, 0);
    check("rst_r_data", r_data, 0);
    check("rst_ids_resp", {56'b0, b_id, r_id}, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // 1: single write then read back
    do_write(4'h1, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    check("t1_b_resp", 64'(last_b_resp), 0);
    do_read(4'h2, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 16'hFFFF, fk, lk, nb);
    check("t1_r_data", last_r_data, 64'hDEAD_BEEF_0123_4567);
    check("t1_latency", 64'(fk), 1);

    // 2: INCR burst of four
    obs_wr_addr.delete();
    do_write(4'h3, 64'h8000_0100, 8'd3, 3'd3, 2'b01, 64'hA5A5_0000_0000_0000, 8'hFF);
    check("t2_wr_count", 64'(obs_wr_addr.size()), 4);
    if (obs_wr_addr.size() == 4) begin
      check("t2_wr_addr0", obs_wr_addr[0], 64'h8000_0100);
      check("t2_wr_addr1", obs_wr_addr[1], 64'h8000_0108);
      check("t2_wr_addr2", obs_wr_addr[2], 64'h8000_0110);
      check("t2_wr_addr3", obs_wr_addr[3], 64'h8000_0118);
    end
    do_read(4'h4, 64'h8000_0100, 8'd3, 3'd3, 2'b01, 16'hFFFF, fk, lk, nb);
    check("t2_first", 64'(fk), 1);
    check("t2_back_to_back", 64'(lk), 4);
    check("t2_last_data", last_r_data, 64'hA5A5_0000_0000_0003);

    // 3: narrow strobed write over all-ones
    do_write(4'h5, 64'h8000_0200, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(4'h5, 64'h8000_0200, 8'd0, 3'd2, 2'b01, 64'h1111_1111_2222_2222, 8'h0F);
    do_read(4'h6, 64'h8000_0200, 8'd0, 3'd3, 2'b01, 16'hFFFF, fk, lk, nb);
    check("t3_merge", last_r_data, 64'hFFFF_FFFF_2222_2222);

    // 4: error paths
    obs_wr_addr.delete();
    do_write(4'h7, 64'h8000_0300, 8'd1, 3'd3, 2'b10, 64'h1234, 8'hFF);
    check("t4_no_write", 64'(obs_wr_addr.size()), 0);
    check("t4_b_slverr", 64'(last_b_resp), 2);
    do_read(4'h8, 64'h8000_0000, 8'd0, 3'd4, 2'b01, 16'hFFFF, fk, lk, nb);
    check("t4_r_slverr", 64'(last_r_resp), 2);
    check("t4_r_zero", last_r_data, 0);
    check("t4_r_beats", 64'(nb), 1);

    // 5: FIXED read with backpressure 1-0-0-1-1 once data is valid
    do_read(4'h9, 64'h8000_0108, 8'd2, 3'd3, 2'b00, 16'hFFF3, fk, lk, nb);
    check("t5_beats", 64'(nb), 3);
    check("t5_done_cycle", 64'(lk), 5);
    check("t5_data", last_r_data, 64'hA5A5_0000_0000_0001);

    // 6: reset in the middle of a len-7 read
    model_off = 1'b1;
    ar_id = 4'hA; ar_addr = 64'h8000_0100; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01;
    ar_valid = 1'b1;
    wait_sig(2, "ar6");
    ar_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    check("t6_pre_valid", 64'(r_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_r_valid", 64'(r_valid), 0);
    check("t6_async_ar_ready", 64'(ar_ready), 0);
    check("t6_async_rd_en", 64'(mem_rd_en), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6_ar_ready", 64'(ar_ready), 1);
    check("t6_no_stale_r", 64'(r_valid), 0);
    @(posedge clk); #1;
    r_ready = 1'b0;
    model_off = 1'b0;
    do_read(4'hB, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 16'hFFFF, fk, lk, nb);
    check("t6_fresh_data", last_r_data, 64'hDEAD_BEEF_0123_4567);
    check("t6_fresh_latency", 64'(fk), 1);

    repeat (3) @(posedge clk);
    check("end_wr_q", 64'(exp_wr_q.size()), 0);
    check("end_rd_q", 64'(exp_rd_q.size()), 0);
    check("end_r_q", 64'(exp_r_q.size()), 0);
    check("end_b_q", 64'(exp_b_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
